alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- ID/EX boundary stage that feeds the combinational ALU.
- Accepts one decoded instruction per cycle from decode.
- Resolves operands: register file, EX forward or MEM forward for rs1/rs2; pc for operand a or immediate for operand b.
- Detects load-use hazards, and registers the operands, funct3, funct7 and destination into the EX pipeline register with a valid/ready handshake. Supports flush.

Parameters:
- XLEN, 32, data/operand width
- REG_IDX_W, 5, register index width
- STALL_CNT_W, 32, width of the load-use stall counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  kill the held instruction and the incoming instruction (branch/jump redirect)
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts it this cycle
- id_pc  in  XLEN  instruction pc
- id_rs1, id_rs2, id_rd  in  REG_IDX_W  register indices
- id_uses_rs1, id_uses_rs2  in  1  operand actually read (hazard qualifier)
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data (combinational read, WB write visible same cycle)
- id_imm  in  XLEN  sign-extended immediate
- id_sel_a  in  1  0 = rs1, 1 = pc
- id_sel_b  in  1  0 = rs2, 1 = imm
- id_funct3  in  3  ALU op
- id_funct7  in  7  ALU modifier
- id_is_load  in  1  instruction is a load
- alu_result  in  XLEN  ALU output for the instruction held here
- mem_valid  in  1  MEM stage holds a register-writing instruction
- mem_rd  in  REG_IDX_W  MEM stage destination
- mem_data  in  XLEN  MEM stage result
- ex_ready  in  1  downstream accepts the held instruction
- ex_valid  out  1  held instruction valid
- ex_a, ex_b  out  XLEN  ALU operands
- ex_funct3  out  3  to ALU
- ex_funct7  out  7  to ALU
- ex_rd  out  REG_IDX_W  held destination
- ex_is_load  out  1  held instruction is a load
- ex_store_data  out  XLEN  forwarded rs2 value, independent of id_sel_b
- ex_pc  out  XLEN  held pc
- stall_count  out  STALL_CNT_W  load-use bubbles inserted since reset (wraps)

Behaviour:
- Reset:
  - ex_valid=0; ex_a, ex_b, ex_store_data, ex_pc = 0.
  - ex_funct3=0, ex_funct7=0, ex_rd=0, ex_is_load=0, stall_count=0.
- Forward value per source register r (idx):
  - idx==0 gives 0.
  - Otherwise EX forward if ex_valid && !ex_is_load && ex_rd==idx, giving alu_result.
  - Otherwise MEM forward if mem_valid && mem_rd==idx, giving mem_data.
  - Otherwise the id_rsX_data input.
  - Priority is EX > MEM > regfile.
- Hazard:
  - Raised when ex_valid && ex_is_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- advance = !ex_valid || ex_ready.
- id_ready = advance && !hazard && !flush (combinational).
- Per clock edge, in priority order:
  1. reset: as above.
  2. flush: ex_valid<=0; the incoming instruction is dropped; stall_count unchanged.
  3. !advance: all ex_* registers hold.
  4. advance && hazard && id_valid: ex_valid<=0 (bubble); stall_count+=1.
  5. advance && id_valid && !hazard: ex_a<= id_sel_a ? id_pc : fwd(rs1); ex_b<= id_sel_b ? id_imm : fwd(rs2); ex_store_data<=fwd(rs2); remaining fields copied; ex_valid<=1.
  6. advance && !id_valid: ex_valid<=0.
- Latency: one cycle from id accept to ex_valid.
- Throughput: one instruction per cycle with no hazard and ex_ready=1.
- The load-use bubble costs exactly one cycle. The next cycle the load is in MEM and forwards via mem_data.
- Payload registers may update freely while ex_valid=0; only ex_valid is architecturally meaningful.
- Stall counter wraps modulo 2^STALL_CNT_W.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, REG_IDX_W
  - typedef issue_payload_t (a, b, store_data, pc, funct3, funct7, rd, is_load)
  - constants SEL_A_RS1/SEL_A_PC and SEL_B_RS2/SEL_B_IMM
- One sub-module, operand_forward, is natural. It is the combinational per-register forward mux and is instantiated twice.

Test Plan:
- Back-to-back dependency:
  - Stimulus: addi x1,x0,5 (imm 5, sel_b=1) accepted; next cycle add x2,x1,x1 with alu_result=5 and id_rs1_data=stale 0.
  - Required: ex_a=5, ex_b=5, no stall.
- MEM forward:
  - Stimulus: mem_valid=1, mem_rd=3, mem_data=0xDEAD; ex_rd=4; instruction reads x3.
  - Required: ex_a=0xDEAD.
  - With ex_rd=3 non-load and alu_result=0x1234: ex_a=0x1234 (EX wins).
- Load-use:
  - Stimulus: held load ex_rd=7; id instruction uses rs2=7.
  - Required: id_ready=0, bubble (ex_valid=0), stall_count=1.
  - Next cycle with mem_rd=7, mem_data=0x55: ex_b=0x55, ex_valid=1.
- x0 and unused operands:
  - Stimulus: rd=0 matches in EX and MEM.
  - Required: operand=0 and no forward.
  - Stimulus: held load rd=5 while id_uses_rs2=0 and id_rs2=5.
  - Required: no stall.
- Backpressure:
  - Stimulus: ex_ready=0 for 3 cycles with id_valid=1.
  - Required: ex_* stable, id_ready=0.
  - Stimulus: ex_ready rises.
  - Required: next instruction latched in that cycle's edge.
- Flush and reset:
  - Stimulus: flush with ex_valid=1 and id_valid=1.
  - Required: ex_valid=0 next cycle, id_ready=0, stall_count unchanged.
  - Stimulus: reset mid-stream.
  - Required: all outputs return to reset values in one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the ID/EX issue stage.
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic SEL_A_RS1 = 1'b0;
   localparam logic SEL_A_PC  = 1'b1;
   localparam logic SEL_B_RS2 = 1'b0;
   localparam logic SEL_B_IMM = 1'b1;

   typedef struct packed {
      logic [XLEN-1:0]      a;
      logic [XLEN-1:0]      b;
      logic [XLEN-1:0]      store_data;
      logic [XLEN-1:0]      pc;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      logic [REG_IDX_W-1:0] rd;
      logic                 is_load;
   } issue_payload_t;

endpackage

// File: rtl/alu_issue_operand_forward.sv
// Per-source-register forward mux: x0 forces zero, then EX result, then MEM result, then regfile.
module operand_forward #(
   parameter int W     = 32,
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [W-1:0]     rf_data,
   input  logic             ex_fwd_en,
   input  logic [IDX_W-1:0] ex_rd,
   input  logic [W-1:0]     ex_data,
   input  logic             mem_fwd_en,
   input  logic [IDX_W-1:0] mem_rd,
   input  logic [W-1:0]     mem_data,
   output logic [W-1:0]     fwd
);

   always_comb begin
      fwd = rf_data;
      if (idx == '0) begin
         fwd = '0;
      end else if (ex_fwd_en && (ex_rd == idx)) begin
         fwd = ex_data;
      end else if (mem_fwd_en && (mem_rd == idx)) begin
         fwd = mem_data;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: operand resolution with forwarding, load-use bubble insertion,
// and the EX pipeline register behind a valid/ready handshake.
module alu_issue
   import cpu_pkg::issue_payload_t, cpu_pkg::SEL_A_PC, cpu_pkg::SEL_B_IMM;
#(
   parameter int XLEN        = 32,
   parameter int REG_IDX_W   = 5,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   id_valid,
   output logic                   id_ready,
   input  logic [XLEN-1:0]        id_pc,
   input  logic [REG_IDX_W-1:0]   id_rs1,
   input  logic [REG_IDX_W-1:0]   id_rs2,
   input  logic [REG_IDX_W-1:0]   id_rd,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [XLEN-1:0]        id_rs1_data,
   input  logic [XLEN-1:0]        id_rs2_data,
   input  logic [XLEN-1:0]        id_imm,
   input  logic                   id_sel_a,
   input  logic                   id_sel_b,
   input  logic [2:0]             id_funct3,
   input  logic [6:0]             id_funct7,
   input  logic                   id_is_load,
   input  logic [XLEN-1:0]        alu_result,
   input  logic                   mem_valid,
   input  logic [REG_IDX_W-1:0]   mem_rd,
   input  logic [XLEN-1:0]        mem_data,
   input  logic                   ex_ready,
   output logic                   ex_valid,
   output logic [XLEN-1:0]        ex_a,
   output logic [XLEN-1:0]        ex_b,
   output logic [2:0]             ex_funct3,
   output logic [6:0]             ex_funct7,
   output logic [REG_IDX_W-1:0]   ex_rd,
   output logic                   ex_is_load,
   output logic [XLEN-1:0]        ex_store_data,
   output logic [XLEN-1:0]        ex_pc,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic                   vld_p1;
   issue_payload_t         pay_p1;
   issue_payload_t         pay_p0;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [XLEN-1:0]        fwd_rs1_p0;
   logic [XLEN-1:0]        fwd_rs2_p0;
   logic                   ex_fwd_en;
   logic                   hazard;
   logic                   advance;

   // A load in EX has no data yet, so it must never feed the EX forward path.
   assign ex_fwd_en = vld_p1 && !pay_p1.is_load;

   operand_forward #(.W(XLEN), .IDX_W(REG_IDX_W)) u_fwd_rs1 (
      .idx        (id_rs1),
      .rf_data    (id_rs1_data),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rd      (pay_p1.rd),
      .ex_data    (alu_result),
      .mem_fwd_en (mem_valid),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .fwd        (fwd_rs1_p0)
   );

   operand_forward #(.W(XLEN), .IDX_W(REG_IDX_W)) u_fwd_rs2 (
      .idx        (id_rs2),
      .rf_data    (id_rs2_data),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rd      (pay_p1.rd),
      .ex_data    (alu_result),
      .mem_fwd_en (mem_valid),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .fwd        (fwd_rs2_p0)
   );

   assign hazard = vld_p1 && pay_p1.is_load && (pay_p1.rd != '0) &&
                   ((id_uses_rs1 && (id_rs1 == pay_p1.rd)) ||
                    (id_uses_rs2 && (id_rs2 == pay_p1.rd)));
   assign advance  = !vld_p1 || ex_ready;
   assign id_ready = advance && !hazard && !flush;

   always_comb begin
      pay_p0            = '0;
      pay_p0.a          = (id_sel_a == SEL_A_PC)  ? id_pc  : fwd_rs1_p0;
      pay_p0.b          = (id_sel_b == SEL_B_IMM) ? id_imm : fwd_rs2_p0;
      pay_p0.store_data = fwd_rs2_p0;
      pay_p0.pc         = id_pc;
      pay_p0.funct3     = id_funct3;
      pay_p0.funct7     = id_funct7;
      pay_p0.rd         = id_rd;
      pay_p0.is_load    = id_is_load;
   end

   // ---- ID -> EX register boundary ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         pay_p1    <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (advance) begin
         if (id_valid && hazard) begin
            vld_p1    <= 1'b0;
            stall_cnt <= stall_cnt + 1'b1;
         end else if (id_valid) begin
            vld_p1 <= 1'b1;
            pay_p1 <= pay_p0;
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign ex_valid      = vld_p1;
   assign ex_a          = pay_p1.a;
   assign ex_b          = pay_p1.b;
   assign ex_store_data = pay_p1.store_data;
   assign ex_pc         = pay_p1.pc;
   assign ex_funct3     = pay_p1.funct3;
   assign ex_funct7     = pay_p1.funct7;
   assign ex_rd         = pay_p1.rd;
   assign ex_is_load    = pay_p1.is_load;
   assign stall_count   = stall_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed cycle table for the corner cases, then randomized traffic against a reference model.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset, flush, id_valid, id_ready;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, alu_result, mem_data;
   logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd;
   logic        id_uses_rs1, id_uses_rs2, id_sel_a, id_sel_b, id_is_load;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   logic        mem_valid, ex_ready, ex_valid, ex_is_load;
   logic [31:0] ex_a, ex_b, ex_store_data, ex_pc, stall_count;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [4:0]  ex_rd;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_sel_a(id_sel_a), .id_sel_b(id_sel_b), .id_funct3(id_funct3), .id_funct7(id_funct7),
      .id_is_load(id_is_load), .alu_result(alu_result), .mem_valid(mem_valid),
      .mem_rd(mem_rd), .mem_data(mem_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_a(ex_a), .ex_b(ex_b), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .stall_count(stall_count)
   );

   typedef struct {
      logic rst, fl, iv;
      logic [4:0] rs1, rs2, rd;
      logic u1, u2;
      logic [31:0] d1, d2, imm, pc;
      logic sa, sb, ld;
      logic [31:0] alu;
      logic mv;
      logic [4:0] mrd;
      logic [31:0] md;
      logic er;
      logic xr, xv;
      logic [31:0] xa, xb, xc;
   } vec_t;

   typedef struct {
      logic valid;
      logic [31:0] a, b, sd, pc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] rd;
      logic ld;
   } held_t;

   held_t       m;
   logic [31:0] m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t v(logic rst, logic fl, logic iv, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic u1, logic u2, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] imm, logic [31:0] pc, logic sa, logic sb, logic ld,
                              logic [31:0] alu, logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic er, logic xr, logic xv, logic [31:0] xa, logic [31:0] xb,
                              logic [31:0] xc);
      vec_t r;
      r.rst = rst; r.fl = fl; r.iv = iv; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
      r.u1 = u1; r.u2 = u2; r.d1 = d1; r.d2 = d2; r.imm = imm; r.pc = pc;
      r.sa = sa; r.sb = sb; r.ld = ld; r.alu = alu; r.mv = mv; r.mrd = mrd; r.md = md;
      r.er = er; r.xr = xr; r.xv = xv; r.xa = xa; r.xb = xb; r.xc = xc;
      return r;
   endfunction

   // Reference forwarding rule, evaluated on the model's held instruction.
   function automatic logic [31:0] m_fwd(logic [4:0] idx, logic [31:0] rf);
      if (idx == 0) return 32'h0;
      if (m.valid && !m.ld && m.rd == idx) return alu_result;
      if (mem_valid && mem_rd == idx) return mem_data;
      return rf;
   endfunction

   vec_t tbl[$];

   initial begin
      reset = 1; flush = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_sel_a = 0; id_sel_b = 0; id_funct3 = 0; id_funct7 = 0; id_is_load = 0;
      alu_result = 0; mem_valid = 0; mem_rd = 0; mem_data = 0; ex_ready = 1;

      //        rst fl iv rs1 rs2 rd  u1 u2 d1     d2     imm    pc        sa sb ld alu       mv mrd md       er xr xv xa        xb     cnt
      tbl.push_back(v(1,0,0, 0,0,0,   0,0, 0,     0,     0,     0,        0,0,0, 0,        0,0,0,       1, 0,0, 0,        0,     0));
      tbl.push_back(v(0,0,1, 0,0,1,   1,0, 0,     0,     5,     'h100,    0,1,0, 0,        0,0,0,       1, 1,1, 0,        5,     0));
      tbl.push_back(v(0,0,1, 1,1,2,   1,1, 0,     0,     0,     'h104,    0,0,0, 5,        0,0,0,       1, 1,1, 5,        5,     0));
      tbl.push_back(v(0,0,1, 0,0,4,   1,0, 0,     0,     7,     'h108,    0,1,0, 'h9,      0,0,0,       1, 1,1, 0,        7,     0));
      tbl.push_back(v(0,0,1, 3,0,3,   1,0, 'h11,  0,     1,     'h10c,    0,1,0, 'h9999,   1,3,'hdead,  1, 1,1, 'hdead,   1,     0));
      tbl.push_back(v(0,0,1, 3,0,5,   1,0, 'h11,  0,     8,     'h110,    0,1,1, 'h1234,   1,3,'hdead,  1, 1,1, 'h1234,   8,     0));
      tbl.push_back(v(0,0,1, 0,5,7,   1,0, 0,     'h77,  0,     'h114,    0,0,1, 'h5555,   0,0,0,       1, 1,1, 0,        'h77,  0));
      tbl.push_back(v(0,0,1, 0,7,8,   1,1, 0,     0,     0,     'h118,    0,0,0, 'h6666,   0,0,0,       1, 0,0, 0,        0,     1));
      tbl.push_back(v(0,0,1, 0,7,8,   1,1, 0,     0,     0,     'h118,    0,0,0, 'h6666,   1,7,'h55,    1, 1,1, 0,        'h55,  1));
      tbl.push_back(v(0,0,1, 0,0,0,   1,1, 'h33,  'h44,  0,     'h11c,    0,0,0, 'hcc,     1,0,'hab,    1, 1,1, 0,        0,     1));
      tbl.push_back(v(0,0,1, 0,0,9,   1,1, 'h33,  'h44,  0,     'h120,    0,0,0, 'hcc,     1,0,'hab,    1, 1,1, 0,        0,     1));
      for (int k = 0; k < 3; k++)
         tbl.push_back(v(0,0,1, 0,0,10, 1,0, 0,   0,     'h11,  'h124,    0,1,0, 0,        0,0,0,       0, 0,1, 0,        0,     1));
      tbl.push_back(v(0,0,1, 0,0,10,  1,0, 0,     0,     'h11,  'h124,    0,1,0, 0,        0,0,0,       1, 1,1, 0,        'h11,  1));
      tbl.push_back(v(0,1,1, 0,0,11,  1,0, 0,     0,     'h22,  'h128,    0,1,0, 0,        0,0,0,       1, 0,0, 0,        0,     1));
      tbl.push_back(v(0,0,1, 0,0,12,  0,0, 0,     0,     4,     'h2000,   1,1,0, 0,        0,0,0,       1, 1,1, 'h2000,   4,     1));
      tbl.push_back(v(0,0,0, 0,0,0,   0,0, 0,     0,     0,     0,        0,0,0, 0,        0,0,0,       1, 1,0, 0,        0,     1));
      tbl.push_back(v(0,0,1, 0,0,3,   0,0, 0,     0,     9,     'h3000,   1,1,0, 0,        0,0,0,       1, 1,1, 'h3000,   9,     1));
      tbl.push_back(v(1,0,1, 0,0,3,   0,0, 0,     0,     9,     'h3000,   1,1,0, 0,        0,0,0,       1, 0,0, 0,        0,     0));

      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rst; flush = tbl[i].fl; id_valid = tbl[i].iv;
         id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
         id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
         id_rs1_data = tbl[i].d1; id_rs2_data = tbl[i].d2; id_imm = tbl[i].imm; id_pc = tbl[i].pc;
         id_sel_a = tbl[i].sa; id_sel_b = tbl[i].sb; id_is_load = tbl[i].ld;
         alu_result = tbl[i].alu; mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
         ex_ready = tbl[i].er;
         #1;
         if (!tbl[i].rst) chk($sformatf("row%0d_id_ready", i), {31'h0, id_ready}, {31'h0, tbl[i].xr});
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_ex_valid", i), {31'h0, ex_valid}, {31'h0, tbl[i].xv});
         chk($sformatf("row%0d_stall_count", i), stall_count, tbl[i].xc);
         if (tbl[i].xv || tbl[i].rst) begin
            chk($sformatf("row%0d_ex_a", i), ex_a, tbl[i].xa);
            chk($sformatf("row%0d_ex_b", i), ex_b, tbl[i].xb);
         end
         if (tbl[i].rst) begin
            chk($sformatf("row%0d_rst_sd_pc", i), ex_store_data | ex_pc, 32'h0);
            chk($sformatf("row%0d_rst_ctl", i), {16'h0, ex_funct3, ex_funct7, ex_rd, ex_is_load}, 32'h0);
         end
      end

      m = '{default: '0};
      m_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         held_t nm;
         logic haz, adv;
         @(negedge clk);
         reset       = (c == 0) || ($urandom_range(0, 199) == 0);
         flush       = ($urandom_range(0, 19) == 0);
         id_valid    = ($urandom_range(0, 4) != 0);
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         id_rd       = 5'($urandom_range(0, 7));
         id_uses_rs1 = 1'($urandom);
         id_uses_rs2 = 1'($urandom);
         id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
         id_sel_a    = 1'($urandom); id_sel_b = 1'($urandom);
         id_funct3   = 3'($urandom); id_funct7 = 7'($urandom);
         id_is_load  = ($urandom_range(0, 2) == 0);
         alu_result  = $urandom;
         mem_valid   = 1'($urandom);
         mem_rd      = 5'($urandom_range(0, 7));
         mem_data    = $urandom;
         ex_ready    = ($urandom_range(0, 3) != 0);
         #1;
         haz = m.valid && m.ld && (m.rd != 0) &&
               ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
         adv = !m.valid || ex_ready;
         if (c != 0) chk("rnd_id_ready", {31'h0, id_ready}, {31'h0, adv && !haz && !flush});
         nm = m;
         if (reset) begin
            nm = '{default: '0};
            m_cnt = 0;
         end else if (flush) begin
            nm.valid = 0;
         end else if (adv && id_valid && haz) begin
            nm.valid = 0;
            m_cnt = m_cnt + 1;
         end else if (adv && id_valid) begin
            nm.valid = 1;
            nm.a  = id_sel_a ? id_pc : m_fwd(id_rs1, id_rs1_data);
            nm.b  = id_sel_b ? id_imm : m_fwd(id_rs2, id_rs2_data);
            nm.sd = m_fwd(id_rs2, id_rs2_data);
            nm.pc = id_pc; nm.f3 = id_funct3; nm.f7 = id_funct7; nm.rd = id_rd; nm.ld = id_is_load;
         end else if (adv) begin
            nm.valid = 0;
         end
         m = nm;
         @(posedge clk);
         #1;
         chk("rnd_ex_valid", {31'h0, ex_valid}, {31'h0, m.valid});
         chk("rnd_stall_count", stall_count, m_cnt);
         if (m.valid) begin
            chk("rnd_ex_a", ex_a, m.a);
            chk("rnd_ex_b", ex_b, m.b);
            chk("rnd_ex_store_data", ex_store_data, m.sd);
            chk("rnd_ex_pc", ex_pc, m.pc);
            chk("rnd_ex_ctl", {16'h0, ex_funct3, ex_funct7, ex_rd, ex_is_load},
                {16'h0, m.f3, m.f7, m.rd, m.ld});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
